// File: rtl/regfile_read_arbiter.sv
// Shares the single register-file read port among NUM_REQ requesters: round-robin arbitration with an optional lock for back-to-back reads.
// Define REGFILE_ARB_FIXED_PRIO_EN to make the lowest eligible index win; the round-robin pointer then does not exist.
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_sel,
  input  logic [NUM_REQ-1:0]     req_lock,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [2:0]             mux_sel,
  input  logic [15:0]            mux_data,
  output logic [15:0]            rd_data,
  output logic [NUM_REQ-1:0]     rd_valid,
  output logic [2:0]             owner_id
);

  localparam logic [0:0]         ST_IDLE   = 1'b0;
  localparam logic [0:0]         ST_LOCKED = 1'b1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  logic [0:0]         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [2:0]         r_mux_sel;
  logic [15:0]        r_rd_data;
  logic [NUM_REQ-1:0] r_rd_valid;
  logic [2:0]         r_owner;

  logic [7:0]         w_elig;
  logic [7:0]         w_req8;
  logic [7:0]         w_lock8;
  logic [3:0]         w_idx;
  logic               w_found;
  logic [2:0]         w_win;
  logic [2:0]         w_win_sel;
  logic [2:0]         w_own_sel;
  logic               w_lock_exit;

  // Padding to 8 bits lets a 3-bit index address any requester without width games.
  assign w_req8  = 8'(req);
  assign w_lock8 = 8'(req_lock);
  // The current grantee is masked so its still-high req is not granted a second time.
  assign w_elig  = 8'(req & ~r_gnt);

  assign w_lock_exit = (r_state == ST_LOCKED) && !(w_req8[r_owner] && w_lock8[r_owner]);

`ifndef REGFILE_ARB_FIXED_PRIO_EN
  logic [2:0] r_rr_ptr;

  function automatic logic [2:0] inc_wrap(input logic [2:0] v);
    return (v == 3'(NUM_REQ - 1)) ? 3'd0 : v + 3'd1;
  endfunction
`endif

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    w_idx   = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      w_idx = 4'(k);
`else
      w_idx = {1'b0, r_rr_ptr} + 4'(k);
      if (w_idx >= 4'(NUM_REQ)) w_idx = w_idx - 4'(NUM_REQ);
`endif
      if (!w_found && w_elig[w_idx[2:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[2:0];
      end
    end
  end

  always_comb begin
    w_win_sel = 3'd0;
    w_own_sel = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (3'(k) == w_win)   w_win_sel = req_sel[3*k +: 3];
      if (3'(k) == r_owner) w_own_sel = req_sel[3*k +: 3];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_mux_sel  <= 3'd0;
      r_rd_data  <= 16'h0000;
      r_rd_valid <= '0;
      r_owner    <= 3'd0;
    end else begin
      r_rd_valid <= r_gnt;
      if (|r_gnt) r_rd_data <= mux_data;
      r_gnt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt     <= ONE_HOT0 << w_win;
            r_mux_sel <= w_win_sel;
            r_owner   <= w_win;
            if (w_lock8[w_win]) r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_req8[r_owner]) begin
            r_gnt     <= ONE_HOT0 << r_owner;
            r_mux_sel <= w_own_sel;
          end
          if (w_lock_exit) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifndef REGFILE_ARB_FIXED_PRIO_EN
  // The pointer is frozen while locked and lands just past the owner on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 3'd0;
    end else if (r_state == ST_IDLE && w_found) begin
      r_rr_ptr <= inc_wrap(w_win);
    end else if (w_lock_exit) begin
      r_rr_ptr <= inc_wrap(r_owner);
    end
  end
`endif

  assign gnt      = r_gnt;
  assign mux_sel  = r_mux_sel;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign owner_id = r_owner;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench for regfile_read_arbiter: directed requester traffic, expected grants/reads queued and checked by a monitor.
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] req_sel = '0;
  logic [3:0]  req_lock = '0;
  logic [3:0]  gnt;
  logic [2:0]  mux_sel;
  logic [15:0] mux_data;
  logic [15:0] rd_data;
  logic [3:0]  rd_valid;
  logic [2:0]  owner_id;

  logic [15:0] rf [8];

  typedef struct {
    logic [3:0] gnt;
    logic [2:0] sel;
    logic [2:0] owner;
  } gnt_t;

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] data;
  } rd_t;

  gnt_t gq[$];
  rd_t  rq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  regfile_read_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_sel(req_sel), .req_lock(req_lock),
    .gnt(gnt), .mux_sel(mux_sel), .mux_data(mux_data), .rd_data(rd_data),
    .rd_valid(rd_valid), .owner_id(owner_id)
  );

  always #5 clk = ~clk;
  assign mux_data = rf[mux_sel];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_read(input int w, input logic [2:0] sel);
    gq.push_back('{gnt: 4'(1) << w, sel: sel, owner: 3'(w)});
    rq.push_back('{vld: 4'(1) << w, data: rf[sel]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requesters raise req, see gnt after the edge, and drop req on the following edge.
  task automatic serve(input logic [3:0] add);
    logic [3:0] seen = '0;
    int n = 0;
    req = req | add;
    while (req != 0 && n < 40) begin
      step();
      req  = req & ~seen;
      seen = gnt & req;
      n++;
    end
    check("serve_done", 32'(req), 32'd0);
    repeat (3) step();
  endtask

  always @(negedge clk) begin
    gnt_t e;
    rd_t  r;
    if (rst_n) begin
      if (gnt != 0) begin
        if (gq.size() == 0) check("unexpected_gnt", 32'(gnt), 32'd0);
        else begin
          e = gq.pop_front();
          check("gnt", 32'(gnt), 32'(e.gnt));
          check("mux_sel", 32'(mux_sel), 32'(e.sel));
          check("owner_id", 32'(owner_id), 32'(e.owner));
        end
      end
      if (rd_valid != 0) begin
        if (rq.size() == 0) check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
        else begin
          r = rq.pop_front();
          check("rd_valid", 32'(rd_valid), 32'(r.vld));
          check("rd_data", 32'(rd_data), 32'(r.data));
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_mux_sel"}, 32'(mux_sel), 32'd0);
    check({tag, "_owner_id"}, 32'(owner_id), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rf[0] = 16'h0F00; rf[1] = 16'h1111; rf[2] = 16'h2222; rf[3] = 16'h3333;
    rf[4] = 16'h4444; rf[5] = 16'hBEEF; rf[6] = 16'h6666; rf[7] = 16'h7777;

    // Power-on reset
    step();
    check_zero("por");
    step();
    rst_n = 1'b1;
    step();

    // Single read of R5 by requester 1 (pointer moves to 2)
    req_sel[5:3] = 3'd5;
    expect_read(1, 3'd5);
    serve(4'b0010);

    // Requesters 1 and 3 competing
    req_sel[5:3] = 3'd1;
    req_sel[11:9] = 3'd6;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    expect_read(1, 3'd1); expect_read(3, 3'd6);
`else
    expect_read(3, 3'd6); expect_read(1, 3'd1);
`endif
    serve(4'b1010);

    // All four requesting, pointer at 2
    req_sel = {3'd7, 3'd4, 3'd3, 3'd2};
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    expect_read(0, 3'd2); expect_read(1, 3'd3); expect_read(2, 3'd4); expect_read(3, 3'd7);
`else
    expect_read(2, 3'd4); expect_read(3, 3'd7); expect_read(0, 3'd2); expect_read(1, 3'd3);
`endif
    serve(4'b1111);

    // Reset while a grant is in flight: nothing may come out afterwards
    req = 4'b1111;
    step();
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    req = '0;
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();

    // All four requesting from a fresh pointer
    expect_read(0, 3'd2); expect_read(1, 3'd3); expect_read(2, 3'd4); expect_read(3, 3'd7);
    serve(4'b1111);

    // Lone requester holding req for 6 cycles gets alternate-cycle grants
    req_sel[2:0] = 3'd4;
    repeat (3) expect_read(0, 3'd4);
    req = 4'b0001;
    repeat (6) step();
    req = '0;
    repeat (3) step();

    // Locked burst by requester 1 (R1,R2,R3) while requester 3 waits
    req_sel[5:3] = 3'd1;
    req_sel[11:9] = 3'd7;
    req_lock = 4'b0010;
    req = 4'b1010;
    expect_read(1, 3'd1);
    step();
    req_sel[5:3] = 3'd2;
    expect_read(1, 3'd2);
    step();
    req_sel[5:3] = 3'd3;
    req_lock = '0;
    expect_read(1, 3'd3);
    step();
    req[1] = 1'b0;
    req_sel[2:0] = 3'd0;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    expect_read(0, 3'd0); expect_read(3, 3'd7);
`else
    expect_read(3, 3'd7); expect_read(0, 3'd0);
`endif
    serve(4'b0001);

    repeat (3) step();
    check("gnt_queue_drained", 32'(gq.size()), 32'd0);
    check("rd_queue_drained", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
